// File: rtl/sound_scheduler.sv
// Arbitrates three note requesters onto one Sound engine: latches one pending note per
// requester, grants one owner at a time, pulses start, and reports done/drop back to the owner.
module sound_scheduler #(
    parameter int OCT_W      = 3,
    parameter int NOTE_W     = 4,
    parameter int LEN_W      = 3,
    parameter int GAP_CYCLES = 0,
    parameter int RR         = 0,
    parameter int PREEMPT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [2:0]          req,
    input  logic [3*OCT_W-1:0]  oct_in,
    input  logic [3*NOTE_W-1:0] note_in,
    input  logic [3*LEN_W-1:0]  len_in,
    input  logic                sd_over,
    output logic                sd_start,
    output logic [OCT_W-1:0]    sd_octave,
    output logic [NOTE_W-1:0]   sd_note,
    output logic [LEN_W-1:0]    sd_length,
    output logic [2:0]          grant,
    output logic [2:0]          done,
    output logic [2:0]          drop,
    output logic                busy
);

    typedef enum logic [1:0] {IDLE, START, PLAY, GAP} state_t;

    localparam int GW = $clog2(GAP_CYCLES + 2);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_t              state_q, state_d;
    logic [2:0]          pend_q, pend_d;
    logic [3*OCT_W-1:0]  oct_slot_q, oct_slot_d;
    logic [3*NOTE_W-1:0] note_slot_q, note_slot_d;
    logic [3*LEN_W-1:0]  len_slot_q, len_slot_d;
    logic [1:0]          ptr_q, ptr_d;
    logic [1:0]          owner_q, owner_d;
    logic                play_q, play_d;
    logic [GW-1:0]       gap_q, gap_d;
    logic                start_q, start_d;
    logic [OCT_W-1:0]    oct_q, oct_d;
    logic [NOTE_W-1:0]   note_q, note_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [2:0]          grant_q, grant_d;
    logic [2:0]          done_q, done_d;
    logic [2:0]          drop_q, drop_d;
    logic                busy_q, busy_d;

    logic                do_grant_s;
    logic [1:0]          win_s;
    logic [2:0]          pre_mask_s;

    function automatic logic [1:0] pick_fixed(input logic [2:0] p);
        if (p[0]) begin
            return 2'd0;
        end else if (p[1]) begin
            return 2'd1;
        end else begin
            return 2'd2;
        end
    endfunction

    // Cyclic search starting just after the last winner.
    function automatic logic [1:0] pick_rr(input logic [2:0] p, input logic [1:0] ptr);
        logic [1:0] idx;
        idx = 2'd0;
        case (ptr)
            2'd0:    idx = p[1] ? 2'd1 : (p[2] ? 2'd2 : 2'd0);
            2'd1:    idx = p[2] ? 2'd2 : (p[0] ? 2'd0 : 2'd1);
            default: idx = p[0] ? 2'd0 : (p[1] ? 2'd1 : 2'd2);
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] lower_mask(input logic [1:0] own);
        case (own)
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            default: return 3'b000;
        endcase
    endfunction

    assign pre_mask_s = pend_q & lower_mask(owner_q);

    // Next-state, slot capture, arbitration and output decode.
    always_comb begin
        state_d     = state_q;
        pend_d      = pend_q;
        oct_slot_d  = oct_slot_q;
        note_slot_d = note_slot_q;
        len_slot_d  = len_slot_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        play_d      = play_q;
        gap_d       = gap_q;
        start_d     = 1'b0;
        oct_d       = oct_q;
        note_d      = note_q;
        len_d       = len_q;
        grant_d     = grant_q;
        done_d      = 3'b000;
        drop_d      = 3'b000;
        do_grant_s  = 1'b0;
        win_s       = 2'd0;

        case (state_q)
            IDLE: begin
                if (en && (pend_q != 3'b000)) begin
                    do_grant_s = 1'b1;
                    win_s      = (RR != 0) ? pick_rr(pend_q, ptr_q) : pick_fixed(pend_q);
                    if (RR != 0) begin
                        ptr_d = win_s;
                    end else begin
                        ptr_d = ptr_q;
                    end
                end else begin
                    do_grant_s = 1'b0;
                end
            end
            START: begin
                start_d = 1'b1;
                play_d  = 1'b0;
                state_d = PLAY;
            end
            PLAY: begin
                play_d = 1'b1;
                // Preemption wins over a simultaneous over; over is stale in the first PLAY cycle.
                if ((PREEMPT != 0) && en && (pre_mask_s != 3'b000)) begin
                    drop_d     = grant_q;
                    do_grant_s = 1'b1;
                    win_s      = pick_fixed(pre_mask_s);
                end else if (play_q && sd_over) begin
                    done_d  = grant_q;
                    grant_d = 3'b000;
                    gap_d   = '0;
                    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
                end else begin
                    state_d = PLAY;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + {{(GW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (do_grant_s) begin
            oct_d          = oct_slot_q[int'(win_s)*OCT_W +: OCT_W];
            note_d         = note_slot_q[int'(win_s)*NOTE_W +: NOTE_W];
            len_d          = len_slot_q[int'(win_s)*LEN_W +: LEN_W];
            grant_d        = 3'b001 << win_s;
            owner_d        = win_s;
            pend_d[win_s]  = 1'b0;
            state_d        = START;
        end else begin
            owner_d = owner_q;
        end

        // A request on the grant edge refills the slot after the grant read the old contents.
        for (int i = 0; i < 3; i++) begin
            if (req[i]) begin
                pend_d[i]                        = 1'b1;
                oct_slot_d[i*OCT_W +: OCT_W]     = oct_in[i*OCT_W +: OCT_W];
                note_slot_d[i*NOTE_W +: NOTE_W]  = note_in[i*NOTE_W +: NOTE_W];
                len_slot_d[i*LEN_W +: LEN_W]     = len_in[i*LEN_W +: LEN_W];
            end else begin
                pend_d[i] = pend_d[i];
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            pend_q      <= 3'b000;
            oct_slot_q  <= '0;
            note_slot_q <= '0;
            len_slot_q  <= '0;
            ptr_q       <= 2'd2;
            owner_q     <= 2'd0;
            play_q      <= 1'b0;
            gap_q       <= '0;
            start_q     <= 1'b0;
            oct_q       <= '0;
            note_q      <= '0;
            len_q       <= '0;
            grant_q     <= 3'b000;
            done_q      <= 3'b000;
            drop_q      <= 3'b000;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            oct_slot_q  <= oct_slot_d;
            note_slot_q <= note_slot_d;
            len_slot_q  <= len_slot_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            play_q      <= play_d;
            gap_q       <= gap_d;
            start_q     <= start_d;
            oct_q       <= oct_d;
            note_q      <= note_d;
            len_q       <= len_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            drop_q      <= drop_d;
            busy_q      <= busy_d;
        end
    end

    assign sd_start  = start_q;
    assign sd_octave = oct_q;
    assign sd_note   = note_q;
    assign sd_length = len_q;
    assign grant     = grant_q;
    assign done      = done_q;
    assign drop      = drop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: fixed-priority/preempting instance plus a round-robin instance.
module tb_sound_scheduler;

    logic        clk, rst, en;
    logic [2:0]  req, req_r;
    logic [8:0]  oct_in;
    logic [11:0] note_in;
    logic [8:0]  len_in;
    logic        sd_over, sd_over_r;

    logic        sd_start, start_rr;
    logic [2:0]  sd_octave, oct_rr;
    logic [3:0]  sd_note, note_rr;
    logic [2:0]  sd_length, len_rr;
    logic [2:0]  grant, grant_rr, done, done_rr, drop, drop_rr;
    logic        busy, busy_rr;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [2:0] g;
        logic [2:0] o;
        logic [3:0] n;
        logic [2:0] l;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int         idx;
        logic [2:0] o;
        logic [3:0] n;
        logic [2:0] l;
        int         dly;
        logic [2:0] exp_g;
    } vec_t;

    sound_scheduler #(.RR(0), .PREEMPT(1)) dut (
        .clk(clk), .rst(rst), .en(en), .req(req),
        .oct_in(oct_in), .note_in(note_in), .len_in(len_in), .sd_over(sd_over),
        .sd_start(sd_start), .sd_octave(sd_octave), .sd_note(sd_note), .sd_length(sd_length),
        .grant(grant), .done(done), .drop(drop), .busy(busy)
    );

    sound_scheduler #(.RR(1), .PREEMPT(0)) dut_rr (
        .clk(clk), .rst(rst), .en(en), .req(req_r),
        .oct_in(oct_in), .note_in(note_in), .len_in(len_in), .sd_over(sd_over_r),
        .sd_start(start_rr), .sd_octave(oct_rr), .sd_note(note_rr), .sd_length(len_rr),
        .grant(grant_rr), .done(done_rr), .drop(drop_rr), .busy(busy_rr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int i, input logic [2:0] o, input logic [3:0] n, input logic [2:0] l);
        oct_in[i*3 +: 3]  = o;
        note_in[i*4 +: 4] = n;
        len_in[i*3 +: 3]  = l;
    endtask

    task automatic push(input logic [2:0] g, input logic [2:0] o, input logic [3:0] n, input logic [2:0] l);
        exp_t e;
        e.g = g; e.o = o; e.n = n; e.l = l;
        sbq.push_back(e);
    endtask

    // Scoreboard: every start pulse must match the next expected note.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && sd_start) begin
            if (sbq.size() == 0) begin
                check("start_unexpected", 32'd1, 32'd0);
            end else begin
                e = sbq.pop_front();
                check("sb_grant",  32'(grant),     32'(e.g));
                check("sb_octave", 32'(sd_octave), 32'(e.o));
                check("sb_note",   32'(sd_note),   32'(e.n));
                check("sb_length", 32'(sd_length), 32'(e.l));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [4];
        logic [2:0] rr_exp [6];
        int t;

        vt[0] = '{idx: 0, o: 3'd4, n: 4'd1,  l: 3'd2, dly: 5, exp_g: 3'b001};
        vt[1] = '{idx: 1, o: 3'd7, n: 4'd15, l: 3'd7, dly: 0, exp_g: 3'b010};
        vt[2] = '{idx: 2, o: 3'd0, n: 4'd9,  l: 3'd1, dly: 2, exp_g: 3'b100};
        vt[3] = '{idx: 0, o: 3'd3, n: 4'd12, l: 3'd5, dly: 1, exp_g: 3'b001};
        rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        rst = 1'b1; en = 1'b1; req = 3'b000; req_r = 3'b000;
        sd_over = 1'b0; sd_over_r = 1'b0;
        oct_in = '0; note_in = '0; len_in = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(sd_start), 32'd0);
        check("rst_done_drop", 32'({done, drop}), 32'd0);
        check("rst_sd", 32'({sd_octave, sd_note, sd_length}), 32'd0);

        // Round-robin: all requesting continuously.
        req_r = 3'b111;
        for (int i = 0; i < 6; i++) begin
            t = 0;
            while (!start_rr && t < 20) begin
                tick();
                t++;
            end
            check("rr_start_seen", 32'(start_rr), 32'd1);
            check("rr_order", 32'(grant_rr), 32'(rr_exp[i]));
            sd_over_r = 1'b1;
            tick(); tick();
            check("rr_done", 32'(done_rr), 32'(rr_exp[i]));
            sd_over_r = 1'b0;
        end
        req_r = 3'b000;

        // Table-driven single notes.
        for (int v = 0; v < 4; v++) begin
            set_slot(vt[v].idx, vt[v].o, vt[v].n, vt[v].l);
            req = 3'b001 << vt[v].idx;
            push(vt[v].exp_g, vt[v].o, vt[v].n, vt[v].l);
            tick();
            req = 3'b000;
            check("v_pre_grant", 32'(grant), 32'd0);
            tick();
            check("v_grant", 32'(grant), 32'(vt[v].exp_g));
            check("v_busy", 32'(busy), 32'd1);
            check("v_start_early", 32'(sd_start), 32'd0);
            tick();
            check("v_start", 32'(sd_start), 32'd1);
            tick();
            check("v_start_once", 32'(sd_start), 32'd0);
            repeat (vt[v].dly) tick();
            sd_over = 1'b1;
            tick();
            check("v_done", 32'(done), 32'(vt[v].exp_g));
            sd_over = 1'b0;
            tick();
            check("v_done_once", 32'(done), 32'd0);
            check("v_idle", 32'({busy, grant}), 32'd0);
        end

        // Simultaneous requests 1 and 2 under fixed priority.
        set_slot(1, 3'd2, 4'd3, 3'd4);
        set_slot(2, 3'd5, 4'd6, 3'd1);
        req = 3'b110;
        push(3'b010, 3'd2, 4'd3, 3'd4);
        push(3'b100, 3'd5, 4'd6, 3'd1);
        tick();
        req = 3'b000;
        tick();
        check("sim_first", 32'(grant), 32'b010);
        tick(); tick();
        sd_over = 1'b1;
        tick();
        sd_over = 1'b0;
        check("sim_done1", 32'(done), 32'b010);
        check("sim_nodrop", 32'(drop), 32'd0);
        tick();
        check("sim_second", 32'(grant), 32'b100);
        tick(); tick();
        sd_over = 1'b1;
        tick();
        sd_over = 1'b0;
        check("sim_done2", 32'(done), 32'b100);
        tick();

        // Preemption of requester 2 by requester 0.
        set_slot(2, 3'd1, 4'd2, 3'd3);
        req = 3'b100;
        push(3'b100, 3'd1, 4'd2, 3'd3);
        tick();
        req = 3'b000;
        tick();
        check("pre_grant2", 32'(grant), 32'b100);
        tick(); tick();
        set_slot(0, 3'd6, 4'd10, 3'd4);
        req = 3'b001;
        push(3'b001, 3'd6, 4'd10, 3'd4);
        tick();
        req = 3'b000;
        check("pre_no_drop_yet", 32'(drop), 32'd0);
        tick();
        check("pre_drop", 32'(drop), 32'b100);
        check("pre_grant0", 32'(grant), 32'b001);
        check("pre_note", 32'(sd_note), 32'd10);
        check("pre_no_done", 32'(done), 32'd0);
        tick();
        check("pre_restart", 32'(sd_start), 32'd1);
        check("pre_drop_once", 32'(drop), 32'd0);
        tick();
        sd_over = 1'b1;
        tick();
        sd_over = 1'b0;
        check("pre_done", 32'(done), 32'b001);
        tick();

        // en=0: current note completes, pending request waits.
        set_slot(1, 3'd2, 4'd5, 3'd6);
        req = 3'b010;
        push(3'b010, 3'd2, 4'd5, 3'd6);
        tick();
        req = 3'b000;
        tick();
        check("en_grant1", 32'(grant), 32'b010);
        tick(); tick();
        en = 1'b0;
        set_slot(0, 3'd1, 4'd1, 3'd1);
        req = 3'b001;
        tick();
        req = 3'b000;
        tick(); tick();
        check("en_no_preempt", 32'({drop, grant}), 32'(3'b010));
        sd_over = 1'b1;
        tick();
        sd_over = 1'b0;
        check("en_done1", 32'(done), 32'b010);
        tick(); tick();
        check("en_hold", 32'({busy, grant}), 32'd0);
        push(3'b001, 3'd1, 4'd1, 3'd1);
        en = 1'b1;
        tick();
        check("en_resume", 32'(grant), 32'b001);
        tick(); tick();
        sd_over = 1'b1;
        tick();
        sd_over = 1'b0;
        check("en_done0", 32'(done), 32'b001);
        tick();

        // Stale over held across START and first PLAY cycle.
        set_slot(2, 3'd3, 4'd3, 3'd3);
        req = 3'b100;
        push(3'b100, 3'd3, 4'd3, 3'd3);
        tick();
        req = 3'b000;
        tick();
        sd_over = 1'b1;
        tick();
        check("stale_start", 32'({sd_start, done}), 32'(4'b1000));
        tick();
        check("stale_ignored", 32'(done), 32'd0);
        tick();
        check("stale_done", 32'(done), 32'b100);
        sd_over = 1'b0;
        tick();

        // Reset mid-note.
        set_slot(1, 3'd4, 4'd4, 3'd4);
        req = 3'b010;
        push(3'b010, 3'd4, 4'd4, 3'd4);
        tick();
        req = 3'b000;
        tick(); tick(); tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_out", 32'({grant, sd_start, busy}), 32'd0);
        tick();
        rst = 1'b0;
        sd_over = 1'b1;
        t = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if ((done != 3'b000) || (drop != 3'b000) || (grant != 3'b000)) t++;
        end
        sd_over = 1'b0;
        check("mid_quiet", 32'(t), 32'd0);
        check("sb_empty", 32'(sbq.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
